// File: rtl/benes_route_sequencer_pkg.sv
// Shared parameters and types for the Benes route sequencer.
// Route entries bundle the R2M and M2R switch configurations.
package benes_route_sequencer_pkg;

  localparam int STAGE_NUM  = 5;
  localparam int SWITCH_NUM = 16;
  localparam int NUM_ROUTES = 16;
  localparam int LEN_W      = 8;
  localparam int INTC_LAT   = 4;

  localparam int ADDR_W = $clog2(NUM_ROUTES);
  localparam int STG_W  = $clog2(STAGE_NUM);

  typedef logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] sel_arr_t;

  typedef struct packed {
    sel_arr_t mod_sel;
    sel_arr_t slot_sel;
  } benes_route_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

endpackage

// File: rtl/benes_route_sequencer_route_table_ram.sv
// Two-table route register file: sync write, comb read.
// Both tables clear on reset; out-of-range stage writes are dropped.
module benes_route_sequencer_route_table_ram
  import benes_route_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              tbl,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [STG_W-1:0]  wstage,
  input  logic [SWITCH_NUM-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output benes_route_t      rdata
);

  sel_arr_t mod_q  [NUM_ROUTES];
  sel_arr_t mod_d  [NUM_ROUTES];
  sel_arr_t slot_q [NUM_ROUTES];
  sel_arr_t slot_d [NUM_ROUTES];

  // Next table contents: one stage of one entry per write
  always_comb begin
    mod_d  = mod_q;
    slot_d = slot_q;
    if (we && (wstage < STG_W'(STAGE_NUM))) begin
      if (tbl) slot_d[waddr][wstage] = wdata;
      else     mod_d[waddr][wstage]  = wdata;
    end
  end

  // Table storage, zeroed on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ROUTES; i++) begin
        mod_q[i]  <= '0;
        slot_q[i] <= '0;
      end
    end else begin
      mod_q  <= mod_d;
      slot_q <= slot_d;
    end
  end

  assign rdata.mod_sel  = mod_q[raddr];
  assign rdata.slot_sel = slot_q[raddr];

endmodule

// File: rtl/benes_route_sequencer.sv
// Route command sequencer feeding Interconnect_benes selects.
// Issues one beat per non-stalled cycle; data-valid trails by INTC_LAT.
module benes_route_sequencer
  import benes_route_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic                  cfg_tbl,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [STG_W-1:0]      cfg_stage,
  input  logic [SWITCH_NUM-1:0] cfg_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_route,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  i_stall,
  output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] o_module_select,
  output logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] o_slot_select,
  output logic                  o_issue,
  output logic                  o_data_valid,
  output logic                  o_busy
);

  state_t        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  benes_route_t  sel_q, sel_d;
  logic [INTC_LAT-1:0] vld_q, vld_d;
  benes_route_t  rd_route;
  logic          run;
  logic          last;
  logic          accept;

  benes_route_sequencer_route_table_ram u_tbl (
    .clk    (clk),
    .rst    (rst),
    .we     (cfg_we),
    .tbl    (cfg_tbl),
    .waddr  (cfg_addr),
    .wstage (cfg_stage),
    .wdata  (cfg_data),
    .raddr  (cmd_route),
    .rdata  (rd_route)
  );

  // Next-state, beat counting, select latch and valid shift
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    run       = (state_q == S_RUN);
    last      = run && (cnt_q == '0);
    cmd_ready = !run || (last && !i_stall);
    accept    = cmd_valid && cmd_ready;
    o_issue   = run && !i_stall;
    if (o_issue) begin
      cnt_d = cnt_q - LEN_W'(1);
      if (last) state_d = S_IDLE;
    end
    if (accept) begin
      sel_d   = rd_route;
      cnt_d   = cmd_len;
      state_d = S_RUN;
    end
    vld_d = {vld_q[INTC_LAT-2:0], o_issue};
  end

  // State registers; reset drops all in-flight valids
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
    end
  end

  assign o_module_select = sel_q.mod_sel;
  assign o_slot_select   = sel_q.slot_sel;
  assign o_data_valid    = vld_q[INTC_LAT-1];
  assign o_busy          = run || (|vld_q);

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Self-checking bench for benes_route_sequencer.
// Beat scoreboard is filled on accept and drained on issue.
module tb_benes_route_sequencer;
  import benes_route_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cfg_we, cfg_tbl;
  logic [ADDR_W-1:0] cfg_addr;
  logic [STG_W-1:0] cfg_stage;
  logic [SWITCH_NUM-1:0] cfg_data;
  logic cmd_valid, cmd_ready;
  logic [ADDR_W-1:0] cmd_route;
  logic [LEN_W-1:0] cmd_len;
  logic i_stall;
  logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] o_module_select;
  logic [0:STAGE_NUM-1][SWITCH_NUM-1:0] o_slot_select;
  logic o_issue, o_data_valid, o_busy;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int issue_cnt = 0;
  int dv_cnt = 0;
  bit acc_flag = 0;
  int i0, d0;

  benes_route_t exp_q[$];
  int vq[$];
  benes_route_t last_sel;
  sel_arr_t tm[NUM_ROUTES];
  sel_arr_t ts[NUM_ROUTES];

  benes_route_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_we          (cfg_we),
    .cfg_tbl         (cfg_tbl),
    .cfg_addr        (cfg_addr),
    .cfg_stage       (cfg_stage),
    .cfg_data        (cfg_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_route       (cmd_route),
    .cmd_len         (cmd_len),
    .i_stall         (i_stall),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_issue         (o_issue),
    .o_data_valid    (o_data_valid),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    vq.delete();
    last_sel = '0;
    for (int i = 0; i < NUM_ROUTES; i++) begin
      tm[i] = '0;
      ts[i] = '0;
    end
  endtask

  task automatic monitor();
    benes_route_t cur, nb;
    bit exp_rdy, edv;
    cur.mod_sel  = o_module_select;
    cur.slot_sel = o_slot_select;
    cyc_n++;
    acc_flag = 0;
    if (rst) begin
      clear_model();
      return;
    end
    chk("busy", o_busy, (exp_q.size() != 0) || (vq.size() != 0));
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && !i_stall);
    chk("cmd_ready", cmd_ready, exp_rdy);
    chk("issue", o_issue, (exp_q.size() != 0) && !i_stall);
    if (exp_q.size() != 0) begin
      chk("sel", cur, exp_q[0]);
      if (!i_stall) last_sel = exp_q.pop_front();
    end else begin
      chk("sel_hold", cur, last_sel);
    end
    if (o_issue) begin
      issue_cnt++;
      vq.push_back(cyc_n + INTC_LAT);
    end
    edv = (vq.size() != 0) && (vq[0] == cyc_n);
    chk("data_valid", o_data_valid, edv);
    if (edv) void'(vq.pop_front());
    if (o_data_valid) dv_cnt++;
    if (cmd_valid && exp_rdy) begin
      acc_flag = 1;
      nb.mod_sel  = tm[cmd_route];
      nb.slot_sel = ts[cmd_route];
      for (int i = 0; i <= int'(cmd_len); i++) exp_q.push_back(nb);
    end
    if (cfg_we && (cfg_stage < STG_W'(STAGE_NUM))) begin
      if (cfg_tbl) ts[cfg_addr][cfg_stage] = cfg_data;
      else         tm[cfg_addr][cfg_stage] = cfg_data;
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic t, input int a, input int s,
                    input logic [SWITCH_NUM-1:0] d);
    cfg_we    = 1'b1;
    cfg_tbl   = t;
    cfg_addr  = ADDR_W'(a);
    cfg_stage = STG_W'(s);
    cfg_data  = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic send(input int r, input int l);
    bit ok;
    ok        = 0;
    cmd_valid = 1'b1;
    cmd_route = ADDR_W'(r);
    cmd_len   = LEN_W'(l);
    for (int i = 0; i < 50 && !ok; i++) begin
      cyc();
      ok = acc_flag;
    end
    cmd_valid = 1'b0;
    chk("send_accept", ok, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 &&
         (o_busy || exp_q.size() != 0 || vq.size() != 0); i++)
      cyc();
    chk("drain", o_busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 0; cfg_tbl = 0; cfg_addr = '0; cfg_stage = '0;
    cfg_data = '0; cmd_valid = 0; cmd_route = '0; cmd_len = '0;
    i_stall = 0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_issue", o_issue, 1'b0);
    chk("rst_dv", o_data_valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_msel", o_module_select, '0);
    chk("rst_ssel", o_slot_select, '0);
    rst = 1'b0;
    cyc();

    // route 3: shifted nibble patterns, 4-beat burst
    for (int s = 0; s < STAGE_NUM; s++) begin
      wr(1'b0, 3, s, 16'h000F << s);
      wr(1'b1, 3, s, 16'hF000 >> s);
    end
    i0 = issue_cnt; d0 = dv_cnt;
    send(3, 3);
    drain();
    chk("b_issues", issue_cnt - i0, 4);
    chk("b_valids", dv_cnt - d0, 4);
    chk("b_msel4", o_module_select[4], 16'h00F0);
    chk("b_ssel4", o_slot_select[4], 16'h0F00);

    // back-to-back: route 1 len 1 then route 2 len 0
    for (int s = 0; s < STAGE_NUM; s++) begin
      wr(1'b0, 1, s, SWITCH_NUM'(16'h1100 + s));
      wr(1'b1, 1, s, SWITCH_NUM'(16'h1A00 + s));
      wr(1'b0, 2, s, SWITCH_NUM'(16'h2200 + s));
      wr(1'b1, 2, s, SWITCH_NUM'(16'h2B00 + s));
    end
    i0 = issue_cnt; d0 = dv_cnt;
    send(1, 1);
    send(2, 0);
    drain();
    chk("c_issues", issue_cnt - i0, 3);
    chk("c_valids", dv_cnt - d0, 3);

    // two-cycle stall inside a 5-beat burst
    i0 = issue_cnt; d0 = dv_cnt;
    send(3, 4);
    cyc();
    i_stall = 1'b1;
    cyc();
    cyc();
    i_stall = 1'b0;
    drain();
    chk("d_issues", issue_cnt - i0, 5);
    chk("d_valids", dv_cnt - d0, 5);

    // same-cycle write and accept of route 5
    for (int s = 0; s < STAGE_NUM; s++) begin
      wr(1'b0, 5, s, 16'hA5A5);
      wr(1'b1, 5, s, 16'h5A5A);
    end
    cfg_we = 1'b1; cfg_tbl = 1'b0; cfg_addr = ADDR_W'(5);
    cfg_stage = '0; cfg_data = 16'h1234;
    cmd_valid = 1'b1; cmd_route = ADDR_W'(5); cmd_len = LEN_W'(1);
    cyc();
    chk("e_accept", acc_flag, 1'b1);
    cfg_we = 1'b0; cmd_valid = 1'b0;
    chk("e_old", o_module_select[0], 16'hA5A5);
    drain();
    send(5, 0);
    drain();
    chk("e_new", o_module_select[0], 16'h1234);
    chk("e_new_slot", o_slot_select[0], 16'h5A5A);

    // asynchronous reset in the middle of a long burst
    send(3, 7);
    cyc();
    cyc();
    cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("g_ready", cmd_ready, 1'b1);
    chk("g_issue", o_issue, 1'b0);
    chk("g_dv", o_data_valid, 1'b0);
    chk("g_busy", o_busy, 1'b0);
    chk("g_msel", o_module_select, '0);
    chk("g_ssel", o_slot_select, '0);
    cyc();
    rst = 1'b0;
    d0 = dv_cnt;
    repeat (10) cyc();
    chk("g_no_dv", dv_cnt - d0, 0);
    wr(1'b0, 7, 2, 16'hFFFF);
    send(3, 0);
    drain();
    chk("g_tbl_clr", o_module_select, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
